cache_bus_sequencer_2: RTL and testbench
========================================

Name: cache_bus_sequencer_2

Overview:
- Per-core, per-L1 sequencer sitting directly upstream of the MESI/LRU controller.
- On a processor miss or a write to a SHARED line, it arbitrates for the common snoop bus and performs any writeback of a MODIFIED victim.
- It broadcasts BusRd/BusRdX/Invalidate with Address_Com, and samples the other caches' Shared wire.
- It then presents the registered Shared result and fill/update strobes, which the controller and cache block use to commit the new MESI state and LRU.

Parameters:
- ADDR_W, 32, address/data width (matches `ADDRESSSIZE).
- MESI_W, 2, MESI state width (matches `MESI_SIZE).
- TIMEOUT, 64, maximum cycles waiting for Mem_ack before abort.
- CNT_W, 7, watchdog counter width (must hold TIMEOUT).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- PrRd  in  1  processor read request.
- PrWr  in  1  processor write request.
- Address  in  ADDR_W  processor address.
- Hit  in  1  tag match in local cache.
- Current_MESI_state_proc  in  MESI_W  state of the hit line.
- Victim_MESI_state  in  MESI_W  state of the LRU-selected victim.
- Victim_Address  in  ADDR_W  address of the victim line.
- Bus_grant  in  1  arbiter grant.
- Mem_ack  in  1  memory/bus transfer complete.
- Shared_in  in  1  wired-OR hit from other caches, valid in BCAST cycle.
- Bus_req  out  1  arbiter request.
- BusRd  out  1  snoop read broadcast.
- BusRdX  out  1  snoop read-exclusive broadcast.
- Invalidate  out  1  snoop invalidate broadcast.
- Mem_wr  out  1  victim writeback strobe.
- Address_Com  out  ADDR_W  common bus address.
- Shared  out  1  registered Shared_in, to controller.
- Fill_en  out  1  one-cycle line-fill strobe.
- Upd_en  out  1  one-cycle MESI/LRU commit strobe.
- CPU_stall  out  1  processor stall.
- Bus_err  out  1  one-cycle timeout abort flag.

Behaviour:
- Reset (synchronous, rst=1 at clk edge): state IDLE, every output 0, Address_Com 0, latches and counter 0. Reset mid-transaction aborts immediately with no writeback completion.
- States: IDLE, WB_REQ, WB_XFER, REQ, BCAST, WAIT_MEM, DONE.
- IDLE trigger conditions:
  - read miss = PrRd & !Hit.
  - write miss = PrWr & !Hit.
  - write upgrade = PrWr & Hit & state==SHARED.
  - PrRd & PrWr together is treated as a write.
  - Hits in M/E, or read hits in S, create no bus op: Upd_en pulses the same cycle, no stall.
- On trigger: latch Address, op (RD/RDX/INV), Victim_Address and victim-dirty (miss & Victim==MODIFIED).
  - Victim dirty → WB_REQ; otherwise → REQ.
- CPU_stall is combinational: asserted in IDLE when trigger is true, and in every state except IDLE and DONE.
- WB_REQ:
  - Bus_req=1; on Bus_grant → WB_XFER.
- WB_XFER:
  - Address_Com=victim, Mem_wr=1 until Mem_ack; then → REQ.
  - Bus_req stays high across the transition, and grant is re-sampled in REQ.
- REQ:
  - Bus_req=1 until Bus_grant → BCAST.
- BCAST, exactly one cycle:
  - Address_Com=latched address; exactly one of BusRd/BusRdX/Invalidate=1 per op.
  - Shared <= Shared_in.
  - INV → DONE; otherwise → WAIT_MEM.
- WAIT_MEM:
  - Bus_req and Address_Com held; Mem_ack → DONE with Fill_en=1 in DONE.
- Watchdog:
  - The counter clears on entry to WB_XFER and WAIT_MEM and increments each cycle there.
  - Reaching TIMEOUT-1 without Mem_ack → Bus_err pulse, then IDLE with no Fill_en/Upd_en. CPU_stall drops.
- DONE, one cycle:
  - Upd_en=1, Bus_req=0, CPU_stall=0 → IDLE.
- Shared holds its value until the next BCAST.
- Address_Com is 0 whenever the block does not own the bus.
- Bus_grant received while not requesting is ignored.
- Mem_ack outside WB_XFER/WAIT_MEM is ignored.
- Grant loss mid-ownership is not supported: the arbiter holds grant while Bus_req=1.

Decomposition:
- Shared package/def file: MESI encodings (INVALID 00, SHARED 01, EXCLUSIVE 10, MODIFIED 11), bus op encodings RD/RDX/INV, and sequencer state encodings.
- One natural sub-module: bus_watchdog_2 (load/increment/expire counter parameterised by TIMEOUT).

Test Plan:
- Read miss, victim E, Shared_in=1, grant at +2, Mem_ack at +5: BusRd one cycle, Shared=1, Fill_en and Upd_en in DONE, stall released.
- Write to S-line hit, Address=0x0000_1040: Invalidate pulse with Address_Com=0x0000_1040, no Mem_ack wait, Upd_en next cycle, Fill_en=0.
- Write miss, victim M at 0x0000_2000: Mem_wr with Address_Com=0x0000_2000 until ack, then BusRdX with the miss address, Fill_en.
- Write hit in E and PrRd&PrWr simultaneous in M: no Bus_req, Upd_en same cycle, CPU_stall=0.
- Mem_ack withheld for 64 cycles in WAIT_MEM: Bus_err pulse, back to IDLE, Bus_req=0, no Fill_en.
- rst asserted during WB_XFER: next edge, all outputs 0, state IDLE; a later read miss proceeds normally.

Source files
------------

// File: rtl/cache_bus_sequencer_2_pkg.sv
`default_nettype none
//--------------------------------------------------------------------
// cache_bus_sequencer_2_pkg : MESI, bus-op and sequencer state encodings
// Revision: 1.0
//--------------------------------------------------------------------
package cache_bus_sequencer_2_pkg;

  typedef enum logic [1:0] {
    MESI_INVALID   = 2'b00,
    MESI_SHARED    = 2'b01,
    MESI_EXCLUSIVE = 2'b10,
    MESI_MODIFIED  = 2'b11
  } mesi_t;

  typedef enum logic [1:0] {
    OP_RD  = 2'b00,
    OP_RDX = 2'b01,
    OP_INV = 2'b10
  } bus_op_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WB_REQ   = 3'd1,
    ST_WB_XFER  = 3'd2,
    ST_REQ      = 3'd3,
    ST_BCAST    = 3'd4,
    ST_WAIT_MEM = 3'd5,
    ST_DONE     = 3'd6
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/cache_bus_sequencer_2_if.sv
`default_nettype none
//--------------------------------------------------------------------
// cache_bus_sequencer_2_if : processor, cache-state and snoop-bus signals
// Revision: 1.0
//--------------------------------------------------------------------
interface cache_bus_sequencer_2_if #(
  parameter int ADDR_W = 32,
  parameter int MESI_W = 2
);
  logic              PrRd;
  logic              PrWr;
  logic [ADDR_W-1:0] Address;
  logic              Hit;
  logic [MESI_W-1:0] Current_MESI_state_proc;
  logic [MESI_W-1:0] Victim_MESI_state;
  logic [ADDR_W-1:0] Victim_Address;
  logic              Bus_grant;
  logic              Mem_ack;
  logic              Shared_in;
  logic              Bus_req;
  logic              BusRd;
  logic              BusRdX;
  logic              Invalidate;
  logic              Mem_wr;
  logic [ADDR_W-1:0] Address_Com;
  logic              Shared;
  logic              Fill_en;
  logic              Upd_en;
  logic              CPU_stall;
  logic              Bus_err;

  modport master (
    input  PrRd, PrWr, Address, Hit, Current_MESI_state_proc, Victim_MESI_state,
           Victim_Address, Bus_grant, Mem_ack, Shared_in,
    output Bus_req, BusRd, BusRdX, Invalidate, Mem_wr, Address_Com, Shared,
           Fill_en, Upd_en, CPU_stall, Bus_err
  );

  modport slave (
    output PrRd, PrWr, Address, Hit, Current_MESI_state_proc, Victim_MESI_state,
           Victim_Address, Bus_grant, Mem_ack, Shared_in,
    input  Bus_req, BusRd, BusRdX, Invalidate, Mem_wr, Address_Com, Shared,
           Fill_en, Upd_en, CPU_stall, Bus_err
  );
endinterface
`default_nettype wire

// File: rtl/cache_bus_sequencer_2_watchdog.sv
`default_nettype none
//--------------------------------------------------------------------
// bus_watchdog_2 : load/increment counter flagging TIMEOUT-1 cycles waited
// Revision: 1.0
//--------------------------------------------------------------------
module bus_watchdog_2 #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_load,
  input  wire logic i_inc,
  output logic      o_expired
);
  logic [CNT_W-1:0] r_cnt;

  assign o_expired = (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || i_load) begin
      r_cnt <= '0;
    end else if (i_inc && !o_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: rtl/cache_bus_sequencer_2.sv
`default_nettype none
//--------------------------------------------------------------------
// cache_bus_sequencer_2 : snoop-bus sequencer for one L1 (writeback, broadcast, fill)
// Revision: 1.0
//--------------------------------------------------------------------
module cache_bus_sequencer_2
  import cache_bus_sequencer_2_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int MESI_W  = 2,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input wire logic clk,
  input wire logic rst,
  cache_bus_sequencer_2_if.master bus
);
  seq_state_t        r_state, w_next;
  bus_op_t           r_op, w_op;
  logic [ADDR_W-1:0] r_addr, r_victim_addr;
  logic              r_shared;
  logic [MESI_W-1:0] w_cur_mesi, w_vic_mesi;
  logic              w_rd_miss, w_wr_miss, w_upgrade, w_trigger, w_dirty;
  logic              w_wait, w_expired;

  assign w_cur_mesi = bus.Current_MESI_state_proc;
  assign w_vic_mesi = bus.Victim_MESI_state;
  // PrRd together with PrWr is handled as a write
  assign w_rd_miss  = bus.PrRd & ~bus.PrWr & ~bus.Hit;
  assign w_wr_miss  = bus.PrWr & ~bus.Hit;
  assign w_upgrade  = bus.PrWr & bus.Hit & (w_cur_mesi == MESI_SHARED);
  assign w_trigger  = w_rd_miss | w_wr_miss | w_upgrade;
  assign w_dirty    = (w_rd_miss | w_wr_miss) & (w_vic_mesi == MESI_MODIFIED);
  assign w_op       = w_wr_miss ? OP_RDX : (w_upgrade ? OP_INV : OP_RD);
  assign w_wait     = (r_state == ST_WB_XFER) || (r_state == ST_WAIT_MEM);
  assign bus.Shared = r_shared;

  bus_watchdog_2 #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .i_load   (~w_wait),
    .i_inc    (w_wait),
    .o_expired(w_expired)
  );

  always_comb begin
    w_next          = r_state;
    bus.Bus_req     = 1'b0;
    bus.BusRd       = 1'b0;
    bus.BusRdX      = 1'b0;
    bus.Invalidate  = 1'b0;
    bus.Mem_wr      = 1'b0;
    bus.Address_Com = '0;
    bus.Fill_en     = 1'b0;
    bus.Upd_en      = 1'b0;
    bus.CPU_stall   = 1'b0;
    bus.Bus_err     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.CPU_stall = w_trigger;
        bus.Upd_en    = (bus.PrRd | bus.PrWr) & bus.Hit & ~w_upgrade;
        if (w_trigger) w_next = w_dirty ? ST_WB_REQ : ST_REQ;
      end
      ST_WB_REQ: begin
        bus.Bus_req   = 1'b1;
        bus.CPU_stall = 1'b1;
        if (bus.Bus_grant) w_next = ST_WB_XFER;
      end
      ST_WB_XFER: begin
        bus.Bus_req     = 1'b1;
        bus.CPU_stall   = 1'b1;
        bus.Mem_wr      = 1'b1;
        bus.Address_Com = r_victim_addr;
        if (bus.Mem_ack) begin
          w_next = ST_REQ;
        end else if (w_expired) begin
          bus.Bus_err = 1'b1;
          w_next      = ST_IDLE;
        end
      end
      ST_REQ: begin
        bus.Bus_req   = 1'b1;
        bus.CPU_stall = 1'b1;
        if (bus.Bus_grant) w_next = ST_BCAST;
      end
      ST_BCAST: begin
        bus.Bus_req     = 1'b1;
        bus.CPU_stall   = 1'b1;
        bus.Address_Com = r_addr;
        case (r_op)
          OP_RD:   bus.BusRd      = 1'b1;
          OP_RDX:  bus.BusRdX     = 1'b1;
          OP_INV:  bus.Invalidate = 1'b1;
          default: bus.BusRd      = 1'b0;
        endcase
        w_next = (r_op == OP_INV) ? ST_DONE : ST_WAIT_MEM;
      end
      ST_WAIT_MEM: begin
        bus.Bus_req     = 1'b1;
        bus.CPU_stall   = 1'b1;
        bus.Address_Com = r_addr;
        if (bus.Mem_ack) begin
          w_next = ST_DONE;
        end else if (w_expired) begin
          bus.Bus_err = 1'b1;
          w_next      = ST_IDLE;
        end
      end
      ST_DONE: begin
        bus.Upd_en  = 1'b1;
        bus.Fill_en = (r_op != OP_INV);
        w_next      = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_op          <= OP_RD;
      r_addr        <= '0;
      r_victim_addr <= '0;
      r_shared      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && w_trigger) begin
        r_addr        <= bus.Address;
        r_victim_addr <= bus.Victim_Address;
        r_op          <= w_op;
      end
      if (r_state == ST_BCAST) r_shared <= bus.Shared_in;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_cache_bus_sequencer_2.sv
`default_nettype none
//--------------------------------------------------------------------
// tb_cache_bus_sequencer_2 : vector table for IDLE decode plus scoreboarded bus transactions
// Revision: 1.0
//--------------------------------------------------------------------
module tb_cache_bus_sequencer_2;
  import cache_bus_sequencer_2_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_bus_sequencer_2_if bus ();

  cache_bus_sequencer_2 #(
    .ADDR_W(32), .MESI_W(2), .TIMEOUT(64), .CNT_W(7)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int obs_wait;

  typedef struct packed {
    logic       rd;
    logic       wr;
    logic       hit;
    logic [1:0] mesi;
    logic       stall;
    logic       upd;
  } vec_t;

  typedef struct {
    int          n_rd;
    int          n_rdx;
    int          n_inv;
    logic [31:0] bc_addr;
    logic        wb;
    logic [31:0] wb_addr;
    logic        fill;
    logic        upd;
    logic        err;
    logic        shared;
  } exp_t;

  exp_t sb_q[$];
  vec_t vt[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk_exp(input int rd, rdx, inv, input logic [31:0] bc,
                                  input logic wb, input logic [31:0] wba,
                                  input logic fill, upd, err, sh);
    exp_t e;
    e.n_rd = rd; e.n_rdx = rdx; e.n_inv = inv; e.bc_addr = bc;
    e.wb = wb; e.wb_addr = wba; e.fill = fill; e.upd = upd; e.err = err; e.shared = sh;
    return e;
  endfunction

  task automatic idle_inputs();
    bus.PrRd = 0; bus.PrWr = 0; bus.Address = '0; bus.Hit = 0;
    bus.Current_MESI_state_proc = MESI_INVALID; bus.Victim_MESI_state = MESI_INVALID;
    bus.Victim_Address = '0; bus.Bus_grant = 0; bus.Mem_ack = 0; bus.Shared_in = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " Bus_req"},     bus.Bus_req,     0);
    check({tag, " BusRd"},       bus.BusRd,       0);
    check({tag, " BusRdX"},      bus.BusRdX,      0);
    check({tag, " Invalidate"},  bus.Invalidate,  0);
    check({tag, " Mem_wr"},      bus.Mem_wr,      0);
    check({tag, " Address_Com"}, bus.Address_Com, 0);
    check({tag, " Shared"},      bus.Shared,      0);
    check({tag, " Fill_en"},     bus.Fill_en,     0);
    check({tag, " Upd_en"},      bus.Upd_en,      0);
    check({tag, " CPU_stall"},   bus.CPU_stall,   0);
    check({tag, " Bus_err"},     bus.Bus_err,     0);
  endtask

  // Acts as processor, arbiter and memory for one request; grant after gd requesting
  // cycles, ack after ad cycles of Mem_wr or of waiting after the broadcast.
  task automatic run_txn(input string nm, input logic rd, wr, hit, input logic [1:0] cur, vic,
                         input logic [31:0] addr, vaddr, input logic sh,
                         input int gd, ad, input bit ack_en, input exp_t e);
    exp_t got, want;
    int rcnt = 0, wcnt = 0, acnt = 0, nostall = 0;
    bit last_req = 0, last_wr = 0, phase = 0, done = 0;
    got = mk_exp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    obs_wait = 0;
    sb_q.push_back(e);
    for (int i = 0; i < 400 && !done; i++) begin
      @(posedge clk); #1;
      bus.PrRd = (i == 0) ? rd : 1'b0;
      bus.PrWr = (i == 0) ? wr : 1'b0;
      bus.Hit = hit; bus.Current_MESI_state_proc = cur; bus.Victim_MESI_state = vic;
      bus.Address = addr; bus.Victim_Address = vaddr; bus.Shared_in = sh;
      bus.Bus_grant = last_req && (rcnt >= gd);
      bus.Mem_ack = ack_en && ((last_wr && wcnt >= ad) || (phase && acnt >= ad));
      #2;
      if (bus.Bus_req) rcnt++;
      last_req = bus.Bus_req;
      if (bus.Mem_wr) begin wcnt++; got.wb = 1; got.wb_addr = bus.Address_Com; end
      last_wr = bus.Mem_wr;
      if (bus.BusRd) got.n_rd++;
      if (bus.BusRdX) got.n_rdx++;
      if (bus.Invalidate) got.n_inv++;
      if (bus.BusRd || bus.BusRdX || bus.Invalidate) begin
        phase = 1; got.bc_addr = bus.Address_Com;
      end else if (phase && bus.Bus_req) begin
        obs_wait++;
      end
      if (phase) acnt++;
      if (bus.Upd_en || bus.Bus_err) begin
        done = 1; got.upd = bus.Upd_en; got.fill = bus.Fill_en;
        got.err = bus.Bus_err; got.shared = bus.Shared;
      end else if (!bus.CPU_stall) begin
        nostall++;
      end
    end
    want = sb_q.pop_front();
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL %s end: no Upd_en/Bus_err within 400 cycles", nm);
    end
    check({nm, " BusRd count"},  got.n_rd,    want.n_rd);
    check({nm, " BusRdX count"}, got.n_rdx,   want.n_rdx);
    check({nm, " Inv count"},    got.n_inv,   want.n_inv);
    check({nm, " bcast addr"},   got.bc_addr, want.bc_addr);
    check({nm, " writeback"},    got.wb,      want.wb);
    check({nm, " wb addr"},      got.wb_addr, want.wb_addr);
    check({nm, " Fill_en"},      got.fill,    want.fill);
    check({nm, " Upd_en"},       got.upd,     want.upd);
    check({nm, " Bus_err"},      got.err,     want.err);
    check({nm, " Shared"},       got.shared,  want.shared);
    check({nm, " stall gaps"},   nostall,     0);
    @(posedge clk); #1;
    bus.Bus_grant = 0; bus.Mem_ack = 0;
    #2;
    check({nm, " after Bus_req"},     bus.Bus_req,     0);
    check({nm, " after CPU_stall"},   bus.CPU_stall,   0);
    check({nm, " after Upd_en"},      bus.Upd_en,      0);
    check({nm, " after Address_Com"}, bus.Address_Com, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    bit seen;
    vt[0]  = '{1'b0, 1'b0, 1'b0, MESI_INVALID,   1'b0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 1'b1, MESI_EXCLUSIVE, 1'b0, 1'b1};
    vt[2]  = '{1'b1, 1'b0, 1'b1, MESI_SHARED,    1'b0, 1'b1};
    vt[3]  = '{1'b1, 1'b0, 1'b1, MESI_MODIFIED,  1'b0, 1'b1};
    vt[4]  = '{1'b0, 1'b1, 1'b1, MESI_EXCLUSIVE, 1'b0, 1'b1};
    vt[5]  = '{1'b1, 1'b1, 1'b1, MESI_MODIFIED,  1'b0, 1'b1};
    vt[6]  = '{1'b0, 1'b1, 1'b1, MESI_SHARED,    1'b1, 1'b0};
    vt[7]  = '{1'b1, 1'b1, 1'b1, MESI_SHARED,    1'b1, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 1'b0, MESI_MODIFIED,  1'b1, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 1'b0, MESI_INVALID,   1'b1, 1'b0};
    vt[10] = '{1'b1, 1'b1, 1'b0, MESI_EXCLUSIVE, 1'b1, 1'b0};

    idle_inputs();
    rst = 1;
    repeat (3) @(posedge clk);
    #2;
    check_zero("reset");
    #2 rst = 0;

    // IDLE decode: requests withdrawn before the edge so no transaction starts
    for (int k = 0; k < 11; k++) begin
      @(posedge clk); #1;
      bus.PrRd = vt[k].rd; bus.PrWr = vt[k].wr; bus.Hit = vt[k].hit;
      bus.Current_MESI_state_proc = vt[k].mesi; bus.Victim_MESI_state = MESI_MODIFIED;
      bus.Address = 32'h0000_0100 + 32'(k);
      #2;
      check($sformatf("vec%0d CPU_stall", k), bus.CPU_stall, vt[k].stall);
      check($sformatf("vec%0d Upd_en", k),    bus.Upd_en,    vt[k].upd);
      check($sformatf("vec%0d Bus_req", k),   bus.Bus_req,   0);
      #1;
      bus.PrRd = 0; bus.PrWr = 0;
    end

    run_txn("rdmiss", 1, 0, 0, MESI_INVALID, MESI_EXCLUSIVE, 32'h0000_0A00, 32'h0000_0B00,
            1, 2, 5, 1, mk_exp(1, 0, 0, 32'h0000_0A00, 0, 0, 1, 1, 0, 1));
    run_txn("wrmiss", 0, 1, 0, MESI_INVALID, MESI_MODIFIED, 32'h3000_0080, 32'h0000_2000,
            0, 1, 3, 1, mk_exp(0, 1, 0, 32'h3000_0080, 1, 32'h0000_2000, 1, 1, 0, 0));
    run_txn("upgrade", 0, 1, 1, MESI_SHARED, MESI_MODIFIED, 32'h0000_1040, 32'h0000_2000,
            1, 0, 2, 1, mk_exp(0, 0, 1, 32'h0000_1040, 0, 0, 0, 1, 0, 1));
    run_txn("timeout", 1, 0, 0, MESI_INVALID, MESI_SHARED, 32'h0000_4400, 32'h0000_4800,
            0, 1, 0, 0, mk_exp(1, 0, 0, 32'h0000_4400, 0, 0, 0, 0, 1, 0));
    check("timeout wait cycles", obs_wait, 64);

    // Reset while the victim writeback is on the bus
    @(posedge clk); #1;
    bus.PrWr = 1; bus.PrRd = 0; bus.Hit = 0; bus.Victim_MESI_state = MESI_MODIFIED;
    bus.Victim_Address = 32'h0000_5000; bus.Address = 32'h0000_6000;
    bus.Bus_grant = 0; bus.Mem_ack = 0; bus.Shared_in = 1;
    @(posedge clk); #1;
    bus.PrWr = 0; bus.Bus_grant = 1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #2;
      seen = bus.Mem_wr;
    end
    check("rstmid wb reached", seen, 1);
    check("rstmid wb addr", bus.Address_Com, 32'h0000_5000);
    @(posedge clk); #1;
    rst = 1; bus.Bus_grant = 0;
    @(posedge clk); #2;
    check_zero("rstmid");
    #2 rst = 0;
    @(posedge clk); #3;
    check_zero("rstmid+1");

    run_txn("postrst", 1, 0, 0, MESI_INVALID, MESI_INVALID, 32'h7000_0040, 32'h0000_0000,
            0, 1, 2, 1, mk_exp(1, 0, 0, 32'h7000_0040, 0, 0, 1, 1, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
